// File: rtl/mem_copier.sv
// mem_copier: word-by-word array copy engine for the UM load-program path.
// Issues one read then one write per word on the shared memory request bus
// and pulses done once the whole source array has been duplicated.

package mem_copier_pkg;
    localparam logic [1:0] MEM_MODE_READ  = 2'b00;
    localparam logic [1:0] MEM_MODE_WRITE = 2'b01;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic [31:0] offset;
        logic [1:0]  mode;
    } mem_in_bus_t;
endpackage

module mem_copier
    import mem_copier_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        start,
    input  logic [31:0] src,
    input  logic [31:0] dest,
    input  logic [31:0] length,
    input  logic [31:0] mem_data_out,
    output mem_in_bus_t mem_in,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dest_q, dest_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;

    // Output registers are loaded from the next-state decode so every
    // request field except write data is a clean flop output.
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] off_q, off_d;
    logic [1:0]  mode_q, mode_d;

    // Next-state, captured-operand and registered-output decode.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dest_d  = dest_q;
        len_d   = len_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src;
                    dest_d  = dest;
                    len_d   = length;
                    idx_d   = 32'd0;
                    state_d = (length == 32'd0) ? DONE : READ;
                end
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                // Terminal compare at len-1 means idx never has to wrap.
                if (idx_q == len_q - 32'd1) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 32'd1;
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
        mode_d = (state_d == WRITE) ? MEM_MODE_WRITE : MEM_MODE_READ;
        addr_d = 32'd0;
        off_d  = 32'd0;
        if (state_d == READ) begin
            addr_d = src_d;
            off_d  = idx_d;
        end else if (state_d == WRITE) begin
            addr_d = dest_d;
            off_d  = idx_d;
        end
    end

    // State and output registers; init wins over any transition.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            src_q   <= 32'd0;
            dest_q  <= 32'd0;
            len_q   <= 32'd0;
            idx_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 32'd0;
            off_q   <= 32'd0;
            mode_q  <= MEM_MODE_READ;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            mode_q  <= mode_d;
        end
    end

    // Write data is the previous cycle's read returning this cycle, so it
    // passes straight through rather than costing another cycle per word.
    assign mem_in = '{
        data:    (state_q == WRITE) ? mem_data_out : 32'd0,
        address: addr_q,
        offset:  off_q,
        mode:    mode_q
    };

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mem_copier.sv
// tb_mem_copier: randomized and directed copies against an array-level
// reference model of memory and of the read/write/done cycle schedule.

module tb_mem_copier;
    import mem_copier_pkg::*;

    localparam int NA = 16;
    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0, dest = '0, length = '0;
    logic [31:0] mem_data_out;
    mem_in_bus_t mem_in;
    logic        busy, done;

    mem_copier dut (
        .clk(clk), .init(init), .start(start), .src(src), .dest(dest),
        .length(length), .mem_data_out(mem_data_out), .mem_in(mem_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // memory fixture: registered read, write commits at the edge
    logic [31:0] mem [NA][NA];
    logic [31:0] ref_mem [NA][NA];
    logic [31:0] rd_q = '0;
    always @(posedge clk) begin
        if (mem_in.mode == 2'b01) mem[mem_in.address[3:0]][mem_in.offset[3:0]] <= mem_in.data;
        rd_q <= mem[mem_in.address[3:0]][mem_in.offset[3:0]];
    end
    assign mem_data_out = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-cycle tables, index = cycle number after the accepting edge
    bit          st_start [NW], st_init [NW];
    logic [31:0] st_src [NW], st_dest [NW], st_len [NW];
    bit          exp_busy [NW], exp_done [NW], exp_wv [NW];
    logic [31:0] exp_wa [NW], exp_wo [NW], exp_wd [NW];
    bit          obs_busy [NW], obs_done [NW], obs_wv [NW], obs_bad [NW];
    logic [31:0] obs_wa [NW], obs_wo [NW], obs_wd [NW];

    bit mon_en = 1'b0;
    int t0 = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            int r;
            r = cyc - t0 + 1;
            if (r >= 1 && r < NW) begin
                obs_busy[r] = busy;
                obs_done[r] = done;
                obs_wv[r]   = (mem_in.mode == 2'b01);
                obs_bad[r]  = mem_in.mode[1];
                obs_wa[r]   = mem_in.address;
                obs_wo[r]   = mem_in.offset;
                obs_wd[r]   = mem_in.data;
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < NW; i++) begin
            st_start[i] = 0; st_init[i] = 0; st_src[i] = '0; st_dest[i] = '0; st_len[i] = '0;
            exp_busy[i] = 0; exp_done[i] = 0; exp_wv[i] = 0;
            exp_wa[i] = '0; exp_wo[i] = '0; exp_wd[i] = '0;
            obs_busy[i] = 0; obs_done[i] = 0; obs_wv[i] = 0; obs_bad[i] = 0;
            obs_wa[i] = '0; obs_wo[i] = '0; obs_wd[i] = '0;
        end
    endtask

    task automatic poke(input int a, input int o, input logic [31:0] v);
        mem[a][o] = v;
        ref_mem[a][o] = v;
    endtask

    // Reference: a copy accepted at cycle base reads word k in base+2k+1,
    // writes it in base+2k+2, done in base+2L+1. Nothing after cycle stop.
    task automatic model_copy(input int base, input int s, input int d, input int l, input int stop);
        if (l == 0) begin
            if (base + 1 <= stop) exp_done[base + 1] = 1;
            return;
        end
        for (int k = 0; k < l; k++) begin
            int wc;
            wc = base + 2 * k + 2;
            if (wc - 1 <= stop) exp_busy[wc - 1] = 1;
            if (wc <= stop) begin
                exp_busy[wc] = 1;
                exp_wv[wc] = 1;
                exp_wa[wc] = d;
                exp_wo[wc] = k;
                exp_wd[wc] = ref_mem[s][k];
                ref_mem[d][k] = ref_mem[s][k];
            end
        end
        if (base + 2 * l + 1 <= stop) exp_done[base + 2 * l + 1] = 1;
    endtask

    task automatic apply(input int r);
        start = st_start[r]; init = st_init[r];
        src = st_src[r]; dest = st_dest[r]; length = st_len[r];
    endtask

    task automatic run(input int w);
        @(posedge clk); #1; apply(0);
        for (int r = 1; r <= w; r++) begin
            @(posedge clk); #1;
            if (r == 1) begin t0 = cyc; mon_en = 1; end
            apply(r);
        end
        @(negedge clk); #1;
        mon_en = 0;
        start = 0; init = 0;
    endtask

    task automatic check_run(input string name, input int w);
        int nd;
        for (int r = 1; r <= w; r++) begin
            chk($sformatf("%s busy@%0d", name, r), obs_busy[r], exp_busy[r]);
            chk($sformatf("%s done@%0d", name, r), obs_done[r], exp_done[r]);
            chk($sformatf("%s wr@%0d", name, r), obs_wv[r], exp_wv[r]);
            chk($sformatf("%s mode@%0d", name, r), obs_bad[r], 1'b0);
            if (exp_wv[r]) begin
                chk($sformatf("%s waddr@%0d", name, r), obs_wa[r], exp_wa[r]);
                chk($sformatf("%s woff@%0d", name, r), obs_wo[r], exp_wo[r]);
                chk($sformatf("%s wdata@%0d", name, r), obs_wd[r], exp_wd[r]);
            end
        end
        nd = 0;
        for (int a = 0; a < NA; a++)
            for (int o = 0; o < NA; o++)
                if (mem[a][o] !== ref_mem[a][o]) nd++;
        chk($sformatf("%s mem", name), nd, 0);
    endtask

    task automatic set_start(input int r, input int s, input int d, input int l);
        st_start[r] = 1; st_src[r] = s; st_dest[r] = d; st_len[r] = l;
    endtask

    initial begin
        for (int a = 0; a < NA; a++)
            for (int o = 0; o < NA; o++)
                poke(a, o, $urandom);

        // reset state
        init = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst mem_in", mem_in, '0);
        init = 0;

        // basic copy
        clear_all();
        poke(5, 0, 32'hA); poke(5, 1, 32'hB); poke(5, 2, 32'hC);
        set_start(0, 5, 9, 3);
        model_copy(0, 5, 9, 3, 999);
        run(9);
        check_run("basic", 9);

        // zero length
        clear_all();
        set_start(0, 1, 2, 0);
        model_copy(0, 1, 2, 0, 999);
        run(4);
        check_run("zero", 4);

        // init during cycle 3 (READ of word 1)
        clear_all();
        set_start(0, 5, 9, 4);
        st_init[3] = 1;
        model_copy(0, 5, 9, 4, 3);
        run(10);
        check_run("rstmid", 10);

        // starts during copy and DONE ignored; start in next IDLE accepted
        clear_all();
        set_start(0, 5, 9, 3);
        set_start(2, 7, 11, 5);
        set_start(7, 7, 10, 2);
        set_start(8, 7, 10, 2);
        model_copy(0, 5, 9, 3, 999);
        model_copy(8, 7, 10, 2, 999);
        run(14);
        check_run("ignstart", 14);

        // self copy
        clear_all();
        poke(3, 0, 32'h1234); poke(3, 1, 32'hFFFFFFFF);
        set_start(0, 3, 3, 2);
        model_copy(0, 3, 3, 2, 999);
        run(6);
        check_run("self", 6);
        chk("self done", exp_done[5], obs_done[5]);

        // randomized copies with a stray start somewhere mid-copy
        for (int it = 0; it < 10; it++) begin
            int s, d, l, rc;
            s = $urandom_range(0, NA - 1);
            d = $urandom_range(0, NA - 1);
            l = (it == 0) ? NA : $urandom_range(0, NA);
            clear_all();
            set_start(0, s, d, l);
            rc = $urandom_range(1, 2 * l + 1);
            set_start(rc, $urandom_range(0, NA - 1), $urandom_range(0, NA - 1), $urandom_range(1, NA));
            model_copy(0, s, d, l, 999);
            run(2 * l + 3);
            check_run($sformatf("rnd%0d", it), 2 * l + 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
